// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the program-counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        MODE_BR   = 2'd0,
        MODE_JAL  = 2'd1,
        MODE_JALR = 2'd2,
        MODE_TRAP = 2'd3
    } redirect_mode_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam int INSTR_BYTES_DEFAULT = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect-target, misalignment and link-address computation.
module pc_target_calc
    import pc_gen_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_BYTES = INSTR_BYTES_DEFAULT,
    parameter int ALIGN_BITS  = 2
) (
    input  redirect_mode_e          mode,
    input  logic [ADDR_WIDTH-1:0]   ex_pc,
    input  logic [DATA_WIDTH-1:0]   reg_a_in,
    input  logic [DATA_WIDTH-1:0]   imm,
    input  logic [ADDR_WIDTH-1:0]   trap_vector,
    output logic [ADDR_WIDTH-1:0]   target,
    output logic                    misaligned,
    output logic [ADDR_WIDTH-1:0]   link_addr
);

    localparam logic [ADDR_WIDTH-1:0] KEEP_MASK =
        ~ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [ADDR_WIDTH-1:0] w_reg_a;
    logic [ADDR_WIDTH-1:0] w_imm;
    logic [ADDR_WIDTH-1:0] w_sum_ex;
    logic [ADDR_WIDTH-1:0] w_sum_reg;

    // Wider operands are truncated; narrower ones extended (imm keeps its sign).
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_trunc
        assign w_reg_a = reg_a_in[ADDR_WIDTH-1:0];
        assign w_imm   = imm[ADDR_WIDTH-1:0];
    end else begin : g_ext
        assign w_reg_a = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, reg_a_in};
        assign w_imm   = {{(ADDR_WIDTH-DATA_WIDTH){imm[DATA_WIDTH-1]}}, imm};
    end

    assign w_sum_ex  = ex_pc + w_imm;
    assign w_sum_reg = w_reg_a + w_imm;

    always_comb begin
        target = w_sum_ex;
        case (mode)
            MODE_JALR: target = {w_sum_reg[ADDR_WIDTH-1:1], 1'b0};
            MODE_TRAP: target = trap_vector & KEEP_MASK;
            default:   target = w_sum_ex;
        endcase
    end

    assign misaligned = (mode != MODE_TRAP) && (target[ALIGN_BITS-1:0] != '0);
    assign link_addr  = ex_pc + ADDR_WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/pc_gen_unit.sv
// Registered PC generator: boot/run/halt control, redirects, stall and fetch handshake.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] PC_ADDR     = 32'h8000_0000,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          INSTR_BYTES = INSTR_BYTES_DEFAULT,
    parameter int          ALIGN_BITS  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [1:0]              redirect_mode,
    input  logic                    redirect_taken,
    input  logic [ADDR_WIDTH-1:0]   ex_pc,
    input  logic [DATA_WIDTH-1:0]   reg_a_in,
    input  logic [DATA_WIDTH-1:0]   imm,
    input  logic [ADDR_WIDTH-1:0]   trap_vector,
    input  logic                    stall,
    input  logic                    pc_ready,
    output logic                    pc_valid,
    output logic [ADDR_WIDTH-1:0]   pc_out,
    output logic [ADDR_WIDTH-1:0]   link_addr,
    output logic                    flush,
    output logic                    misalign
);

    pc_state_e             r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_flush;
    logic                  r_misalign;

    redirect_mode_e        w_mode;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_misaligned;
    logic                  w_eff;

    assign w_mode = redirect_mode_e'(redirect_mode);

    pc_target_calc #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .INSTR_BYTES (INSTR_BYTES),
        .ALIGN_BITS  (ALIGN_BITS)
    ) u_target_calc (
        .mode        (w_mode),
        .ex_pc       (ex_pc),
        .reg_a_in    (reg_a_in),
        .imm         (imm),
        .trap_vector (trap_vector),
        .target      (w_target),
        .misaligned  (w_misaligned),
        .link_addr   (link_addr)
    );

    // A not-taken branch is indistinguishable from no redirect at all.
    assign w_eff = redirect_valid && ((w_mode != MODE_BR) || redirect_taken);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= ADDR_WIDTH'(PC_ADDR);
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            if (w_eff && (w_mode == MODE_TRAP)) begin
                r_pc    <= w_target;
                r_flush <= 1'b1;
                r_state <= ST_RUN;
            end else if (w_eff && (r_state != ST_HALT)) begin
                r_flush <= 1'b1;
                if (w_misaligned) begin
                    r_misalign <= 1'b1;
                    r_state    <= ST_HALT;
                end else begin
                    r_pc    <= w_target;
                    r_state <= ST_RUN;
                end
            end else if (r_state == ST_BOOT) begin
                r_state <= ST_RUN;
            end else if ((r_state == ST_RUN) && !stall && pc_ready) begin
                r_pc <= r_pc + ADDR_WIDTH'(INSTR_BYTES);
            end
        end
    end

    assign pc_valid = (r_state == ST_RUN) && !stall;
    assign pc_out   = r_pc;
    assign flush    = r_flush;
    assign misalign = r_misalign;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: driver pushes model predictions, monitor compares after each edge.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_mode = 2'd0;
    logic        redirect_taken = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic [31:0] reg_a_in = 32'h0;
    logic [31:0] imm = 32'h0;
    logic [31:0] trap_vector = 32'h0;
    logic        stall = 1'b0;
    logic        pc_ready = 1'b0;
    logic        pc_valid;
    logic [31:0] pc_out;
    logic [31:0] link_addr;
    logic        flush;
    logic        misalign;

    pc_gen_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_mode  (redirect_mode),
        .redirect_taken (redirect_taken),
        .ex_pc          (ex_pc),
        .reg_a_in       (reg_a_in),
        .imm            (imm),
        .trap_vector    (trap_vector),
        .stall          (stall),
        .pc_ready       (pc_ready),
        .pc_valid       (pc_valid),
        .pc_out         (pc_out),
        .link_addr      (link_addr),
        .flush          (flush),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        v;
        logic [31:0] pc;
        logic        fl;
        logic        ms;
        logic [31:0] link;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_issued = 0;

    // Reference model: the fetch PC plus two flags describing where the unit is.
    logic [31:0] m_pc = 32'h8000_0000;
    bit          m_boot = 1'b1;
    bit          m_halt = 1'b0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %h, required %h", nm, idx, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h8000_0000;
        m_boot = 1'b1;
        m_halt = 1'b0;
    endtask

    // Apply one cycle of stimulus (caller sits just after a negedge) and predict the post-edge outputs.
    task automatic drive(input bit rv, input int mode, input bit tk, input logic [31:0] ex,
                         input logic [31:0] ra, input logic [31:0] im, input logic [31:0] tv,
                         input bit st, input bit rdy);
        exp_t        e;
        logic [31:0] tgt;
        bit          eff, mis, fl, ms;
        redirect_valid = rv;
        redirect_mode  = 2'(mode);
        redirect_taken = tk;
        ex_pc          = ex;
        reg_a_in       = ra;
        imm            = im;
        trap_vector    = tv;
        stall          = st;
        pc_ready       = rdy;

        eff = rv && (mode != 0 || tk);
        case (mode)
            2:       tgt = (ra + im) & 32'hFFFF_FFFE;
            3:       tgt = tv - (tv % 4);
            default: tgt = ex + im;
        endcase
        mis = (mode != 3) && (tgt % 4 != 0);
        fl = 1'b0;
        ms = 1'b0;
        if (eff && mode == 3) begin
            m_pc = tgt; fl = 1'b1; m_boot = 1'b0; m_halt = 1'b0;
        end else if (eff && !m_halt) begin
            fl = 1'b1;
            m_boot = 1'b0;
            if (mis) begin
                ms = 1'b1; m_halt = 1'b1;
            end else begin
                m_pc = tgt;
            end
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halt && !st && rdy) begin
            m_pc = m_pc + 32'd4;
        end

        e.idx  = n_issued;
        e.v    = !m_boot && !m_halt && !st;
        e.pc   = m_pc;
        e.fl   = fl;
        e.ms   = ms;
        e.link = ex + 32'd4;
        exp_q.push_back(e);
        n_issued++;
        @(negedge clk);
    endtask

    task automatic idle(input bit st, input bit rdy);
        drive(1'b0, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, st, rdy);
    endtask

    // Monitor: after every active edge, the registered outputs are the DUT's response.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_valid", e.idx, 32'(pc_valid), 32'(e.v));
                chk("pc_out", e.idx, pc_out, e.pc);
                chk("flush", e.idx, 32'(flush), 32'(e.fl));
                chk("misalign", e.idx, 32'(misalign), 32'(e.ms));
                chk("link_addr", e.idx, link_addr, e.link);
            end
        end
    end

    initial begin : stimulus
        bit          rv, tk, st, rdy;
        int          mode;
        logic [31:0] ex, ra, im, tv;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc_out", -1, pc_out, 32'h8000_0000);
        chk("rst_pc_valid", -1, 32'(pc_valid), 32'h0);
        chk("rst_flush", -1, 32'(flush), 32'h0);
        chk("rst_misalign", -1, 32'(misalign), 32'h0);
        reset = 1'b1;
        #1;
        chk("boot_pc_valid", -1, 32'(pc_valid), 32'h0);

        // Boot and sequential advance
        repeat (3) idle(1'b0, 1'b1);
        repeat (2) idle(1'b0, 1'b0);
        repeat (2) idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);

        // Conditional branch taken / not taken
        drive(1'b1, 0, 1'b1, 32'h8000_0010, 32'h0, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        drive(1'b1, 0, 1'b0, 32'h8000_0010, 32'h0, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1);

        // Misaligned JALR halts; JAL ignored; TRAP recovers with aligned vector
        drive(1'b1, 2, 1'b0, 32'h8000_0020, 32'h8000_1001, 32'h2, 32'h0, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        drive(1'b1, 1, 1'b0, 32'h8000_0040, 32'h0, 32'h8, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 3, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_0203, 1'b0, 1'b1);
        idle(1'b0, 1'b1);

        // JAL with link address, back-to-back redirects, wrap at top of address space
        drive(1'b1, 1, 1'b0, 32'h8000_0040, 32'h0, 32'h8, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 1, 1'b0, 32'h8000_0100, 32'h0, 32'h10, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'hC, 32'h0, 1'b0, 1'b0);
        idle(1'b0, 1'b1);
        drive(1'b1, 1, 1'b0, 32'h8000_0100, 32'h0, 32'h20, 32'h0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a redirect cycle
        redirect_valid = 1'b1;
        redirect_mode  = 2'd1;
        ex_pc          = 32'h8000_0300;
        imm            = 32'h40;
        #2 reset = 1'b0;
        #1;
        chk("async_pc_out", -2, pc_out, 32'h8000_0000);
        chk("async_pc_valid", -2, 32'(pc_valid), 32'h0);
        chk("async_flush", -2, 32'(flush), 32'h0);
        chk("async_misalign", -2, 32'(misalign), 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        model_reset();
        reset = 1'b1;
        repeat (3) idle(1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rv   = ($urandom % 4) == 0;
            mode = int'($urandom % 4);
            tk   = $urandom % 2;
            ex   = $urandom & 32'hFFFF_FFFC;
            ra   = $urandom;
            im   = ($urandom % 3 == 0) ? $urandom : 32'($urandom_range(0, 64) - 32) << 2;
            tv   = $urandom;
            st   = ($urandom % 4) == 0;
            rdy  = ($urandom % 3) != 0;
            drive(rv, mode, tk, ex, ra, im, tv, st, rdy);
        end
        idle(1'b0, 1'b0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
